// File: rtl/id_ex_control.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_control
// Purpose  : Main control decoder and ID/EX control pipeline register.
//            The opcode of the instruction in ID is decoded combinationally
//            into datapath controls and the ALUOp/Funct pair for the EX-stage
//            ALU control unit. Every output is registered, so EX sees the
//            controls one cycle after the instruction is presented in ID.
//            The hazard unit can freeze the register (hold) or insert a
//            bubble (flush). Flush has priority over hold.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   id_instr     in  32   instruction in ID
//   id_valid     in   1   id_instr holds a real instruction
//   hold         in   1   freeze the ID/EX register
//   flush        in   1   load a bubble into the ID/EX register
//   ex_valid     out  1   EX holds a real, legal instruction
//   ex_ALUOp     out  2   00 add, 01 sub, 10 decode Funct
//   ex_Funct     out  4   {funct7[5], funct3}
//   ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc,
//   ex_Branch    out  1   datapath controls
//   ex_rd, ex_rs1, ex_rs2  out 5  register fields
//   ex_illegal   out  1   sticky illegal-opcode flag, cleared only by reset
// ============================================================================
module id_ex_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        hold,
  input  logic        flush,
  output logic        ex_valid,
  output logic [1:0]  ex_ALUOp,
  output logic [3:0]  ex_Funct,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemtoReg,
  output logic        ex_ALUSrc,
  output logic        ex_Branch,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7b5   = id_instr[30];

  // Immediate bits are not needed by control; fold them so lint sees a use.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{id_instr[31], id_instr[29:25]};

  // Combinational decode
  logic       dec_legal;
  logic [1:0] dec_aluop;
  logic [3:0] dec_funct;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_memtoreg;
  logic       dec_alusrc;
  logic       dec_branch;

  always_comb begin
    dec_legal    = 1'b0;
    dec_aluop    = ALUOP_ADD;
    dec_funct    = 4'b0000;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_legal    = 1'b1;
        dec_aluop    = ALUOP_FUNCT;
        dec_funct    = {f7b5, f3};
        dec_regwrite = 1'b1;
      end
      OP_IALU: begin
        // funct7[5] of an I-type is immediate data, so it is masked off.
        dec_legal    = 1'b1;
        dec_aluop    = ALUOP_FUNCT;
        dec_funct    = {1'b0, f3};
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      OP_LOAD: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_regwrite = 1'b1;
      end
      OP_STORE: begin
        dec_legal    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_BRANCH: begin
        dec_legal    = 1'b1;
        dec_aluop    = ALUOP_SUB;
        dec_funct    = {1'b0, f3};
        dec_branch   = 1'b1;
      end
      default: begin
        dec_legal    = 1'b0;
      end
    endcase
  end

  logic load_real;
  logic load_illegal;
  assign load_real    = id_valid & dec_legal;
  assign load_illegal = id_valid & ~dec_legal;

  // ID/EX register. Priority: reset, flush, hold, load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_Funct    <= 4'b0000;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_rd       <= 5'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_illegal  <= 1'b0;
    end else if (flush || (!hold && !load_real)) begin
      // Bubble: flush, invalid slot, or illegal opcode
      ex_valid    <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_Funct    <= 4'b0000;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_rd       <= 5'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      // The sticky flag only records instructions actually loaded.
      if (!flush && load_illegal) begin
        ex_illegal <= 1'b1;
      end
    end else if (!hold) begin
      ex_valid    <= 1'b1;
      ex_ALUOp    <= dec_aluop;
      ex_Funct    <= dec_funct;
      ex_RegWrite <= dec_regwrite;
      ex_MemRead  <= dec_memread;
      ex_MemWrite <= dec_memwrite;
      ex_MemtoReg <= dec_memtoreg;
      ex_ALUSrc   <= dec_alusrc;
      ex_Branch   <= dec_branch;
      ex_rd       <= id_instr[11:7];
      ex_rs1      <= id_instr[19:15];
      ex_rs2      <= id_instr[24:20];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_control
// Purpose  : Self-checking bench for id_ex_control. A table of input vectors
//            with expected registered outputs is applied one per cycle; each
//            expectation is queued when the stimulus is driven and compared
//            after the following rising edge. Reset corner cases are checked
//            with a short hand-written sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_control;

  logic        clk;
  logic        reset_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        hold;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_ALUOp;
  logic [3:0]  ex_Funct;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_MemtoReg;
  logic        ex_ALUSrc;
  logic        ex_Branch;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_illegal;

  id_ex_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .hold       (hold),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ALUOp   (ex_ALUOp),
    .ex_Funct   (ex_Funct),
    .ex_RegWrite(ex_RegWrite),
    .ex_MemRead (ex_MemRead),
    .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUSrc  (ex_ALUSrc),
    .ex_Branch  (ex_Branch),
    .ex_rd      (ex_rd),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
  typedef struct packed {
    logic       valid;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic [5:0] ctl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        hold;
    logic        flush;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] SUB  = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] LW   = 32'h0080A283; // lw   x5,8(x1)
  localparam logic [31:0] BEQ  = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] BNE  = 32'h00209463; // bne  x1,x2,8
  localparam logic [31:0] SRAI = 32'h4050D213; // srai x4,x1,5
  localparam logic [31:0] SW   = 32'h0020A623; // sw   x2,12(x1)
  localparam logic [31:0] ILL  = 32'h0000007F;

  localparam int NVEC = 18;

  int   passed;
  int   total;
  out_t sb_q[$];
  vec_t vecs[NVEC];

  function automatic out_t mk(input logic v, input logic [1:0] a,
                              input logic [3:0] f, input logic [5:0] c,
                              input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic il);
    out_t o;
    o = '{valid: v, aluop: a, funct: f, ctl: c, rd: d, rs1: s1, rs2: s2, ill: il};
    return o;
  endfunction

  function automatic out_t bubble(input logic il);
    return mk(1'b0, 2'b00, 4'b0000, 6'b000000, 5'd0, 5'd0, 5'd0, il);
  endfunction

  function automatic vec_t mv(input logic [31:0] i, input logic v,
                              input logic h, input logic f, input out_t e);
    vec_t r;
    r = '{instr: i, valid: v, hold: h, flush: f, exp: e};
    return r;
  endfunction

  function automatic out_t sample();
    return mk(ex_valid, ex_ALUOp, ex_Funct,
              {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch},
              ex_rd, ex_rs1, ex_rs2, ex_illegal);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v,
                       input logic h, input logic f);
    id_instr = i;
    id_valid = v;
    hold     = h;
    flush    = f;
  endtask

  initial begin
    out_t e_add, e_add_i, e_sub, e_lw, e_beq, e_srai, e_sw, e_bne, e_pop;
    passed = 0;
    total  = 0;

    e_add   = mk(1, 2'b10, 4'b0000, 6'b100000, 5'd3, 5'd1, 5'd2, 1'b0);
    e_add_i = mk(1, 2'b10, 4'b0000, 6'b100000, 5'd3, 5'd1, 5'd2, 1'b1);
    e_sub   = mk(1, 2'b10, 4'b1000, 6'b100000, 5'd3, 5'd1, 5'd2, 1'b0);
    e_lw    = mk(1, 2'b00, 4'b0000, 6'b110110, 5'd5, 5'd1, 5'd8, 1'b0);
    e_beq   = mk(1, 2'b01, 4'b0000, 6'b000001, 5'd8, 5'd1, 5'd2, 1'b0);
    e_srai  = mk(1, 2'b10, 4'b0101, 6'b100010, 5'd4, 5'd1, 5'd5, 1'b1);
    e_sw    = mk(1, 2'b00, 4'b0000, 6'b001010, 5'd12, 5'd1, 5'd2, 1'b1);
    e_bne   = mk(1, 2'b01, 4'b0001, 6'b000001, 5'd8, 5'd1, 5'd2, 1'b1);

    vecs[0]  = mv(ADD,  1, 0, 0, e_add);
    vecs[1]  = mv(SUB,  1, 0, 0, e_sub);
    vecs[2]  = mv(LW,   1, 0, 0, e_lw);
    vecs[3]  = mv(BEQ,  1, 0, 0, e_beq);
    vecs[4]  = mv(ADD,  1, 0, 0, e_add);
    // hold for three cycles with changing ID, including an illegal opcode
    vecs[5]  = mv(SUB,  1, 1, 0, e_add);
    vecs[6]  = mv(ILL,  1, 1, 0, e_add);
    vecs[7]  = mv(LW,   1, 1, 0, e_add);
    // flush+hold loads a bubble (illegal in ID must not set the flag)
    vecs[8]  = mv(ILL,  1, 1, 1, bubble(1'b0));
    vecs[9]  = mv(ADD,  1, 1, 0, bubble(1'b0));
    vecs[10] = mv(SUB,  1, 1, 0, bubble(1'b0));
    // illegal load sets the sticky flag
    vecs[11] = mv(ILL,  1, 0, 0, bubble(1'b1));
    vecs[12] = mv(ADD,  1, 0, 0, e_add_i);
    vecs[13] = mv(ADD,  0, 0, 0, bubble(1'b1));
    vecs[14] = mv(SRAI, 1, 0, 0, e_srai);
    vecs[15] = mv(SW,   1, 0, 0, e_sw);
    vecs[16] = mv(BNE,  1, 0, 0, e_bne);
    vecs[17] = mv(ADD,  1, 0, 1, bubble(1'b1));

    // Reset state
    reset_n = 1'b0;
    drive(ADD, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_state", sample(), bubble(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // Table: one vector per cycle, expectation queued at drive time
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].valid, vecs[i].hold, vecs[i].flush);
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e_pop = sb_q.pop_front();
      check($sformatf("vec%0d", i), sample(), e_pop);
    end

    // Asynchronous reset mid-cycle while outputs are nonzero
    @(negedge clk);
    drive(LW, 1'b1, 1'b1, 1'b0);
    #2;
    check("pre_reset_nonzero", sample(), bubble(1'b1));
    reset_n = 1'b0;
    #1;
    check("async_reset_midcycle", sample(), bubble(1'b0));
    @(posedge clk);
    #1;
    check("reset_held_edge", sample(), bubble(1'b0));

    // Release reset between edges; outputs stay zero until the next edge
    @(negedge clk);
    drive(LW, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    check("post_release_zero", sample(), bubble(1'b0));
    sb_q.push_back(e_lw);
    @(posedge clk);
    #1;
    e_pop = sb_q.pop_front();
    check("first_load_after_reset", sample(), e_pop);

    if (sb_q.size() != 0) begin
      total = total + 1;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
